// File: rtl/sdio_cmd_engine.sv
// rtl/sdio_cmd_engine.sv - SD CMD-line engine: frame serialiser with CRC7, response capture and check.
// Optional NCR timeout counter enabled by defining SDIO_CMD_TIMEOUT_EN.
module sdio_cmd_engine #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1),
    parameter int RESP_W         = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clk_en_i,
    input  logic              start_i,
    input  logic [5:0]        cmd_index_i,
    input  logic [31:0]       cmd_arg_i,
    input  logic [1:0]        resp_type_i,
    input  logic              cmd_in_i,
    output logic              cmd_out_o,
    output logic              cmd_oe_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [5:0]        resp_index_o,
    output logic [RESP_W-1:0] resp_data_o,
    output logic              crc_err_o,
    output logic              end_err_o,
    output logic              timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_WAIT,
        S_RX,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [39:0]         tx_sh_q;
    logic [6:0]          crc_q;
    logic [7:0]          bit_cnt_q;
    logic [1:0]          rtype_q;
    logic [132:0]        rx_sh_q;
    logic                cmd_out_q;
    logic                cmd_oe_q;
    logic                busy_q;
    logic                done_q;
    logic [5:0]          resp_index_q;
    logic [RESP_W-1:0]   resp_data_q;
    logic                crc_err_q;
    logic                end_err_q;
`ifdef SDIO_CMD_TIMEOUT_EN
    logic [TO_W-1:0]     to_cnt_q;
    logic                timeout_q;
`endif

    logic [133:0]        rx_full_d;
    logic [7:0]          rx_bit_n_d;
    logic [7:0]          rx_len_d;
    logic                rx_long_d;
    logic                rx_in_crc_d;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        crc7_step = {c[5:0], 1'b0} ^ (((b ^ c[6]) == 1'b1) ? 7'h09 : 7'h00);
    endfunction

    // rx_full_d is the received frame as it stands once the current bit is included.
    always_comb begin
        rx_full_d   = {rx_sh_q, cmd_in_i};
        rx_bit_n_d  = bit_cnt_q + 8'd1;
        rx_long_d   = (rtype_q == 2'b11);
        rx_len_d    = rx_long_d ? 8'd136 : 8'd48;
        rx_in_crc_d = rx_long_d ? ((rx_bit_n_d >= 8'd9) && (rx_bit_n_d <= 8'd128))
                                : (rx_bit_n_d <= 8'd40);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            tx_sh_q      <= '0;
            crc_q        <= '0;
            bit_cnt_q    <= '0;
            rtype_q      <= '0;
            rx_sh_q      <= '0;
            cmd_out_q    <= 1'b1;
            cmd_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            resp_index_q <= '0;
            resp_data_q  <= '0;
            crc_err_q    <= 1'b0;
            end_err_q    <= 1'b0;
`ifdef SDIO_CMD_TIMEOUT_EN
            to_cnt_q     <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        tx_sh_q      <= {2'b01, cmd_index_i, cmd_arg_i};
                        rtype_q      <= resp_type_i;
                        crc_q        <= '0;
                        bit_cnt_q    <= '0;
                        rx_sh_q      <= '0;
                        resp_index_q <= '0;
                        resp_data_q  <= '0;
                        crc_err_q    <= 1'b0;
                        end_err_q    <= 1'b0;
`ifdef SDIO_CMD_TIMEOUT_EN
                        to_cnt_q     <= '0;
                        timeout_q    <= 1'b0;
`endif
                        busy_q       <= 1'b1;
                        state_q      <= S_TX;
                    end
                end
                S_TX: begin
                    if (clk_en_i) begin
                        if (bit_cnt_q < 8'd40) begin
                            cmd_out_q <= tx_sh_q[39];
                            cmd_oe_q  <= 1'b1;
                            tx_sh_q   <= {tx_sh_q[38:0], 1'b0};
                            crc_q     <= crc7_step(crc_q, tx_sh_q[39]);
                            bit_cnt_q <= bit_cnt_q + 8'd1;
                        end else if (bit_cnt_q < 8'd47) begin
                            // CRC register drains MSB first after the 40 covered bits.
                            cmd_out_q <= crc_q[6];
                            cmd_oe_q  <= 1'b1;
                            crc_q     <= {crc_q[5:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + 8'd1;
                        end else if (bit_cnt_q == 8'd47) begin
                            cmd_out_q <= 1'b1;
                            cmd_oe_q  <= 1'b1;
                            bit_cnt_q <= bit_cnt_q + 8'd1;
                        end else begin
                            cmd_out_q <= 1'b1;
                            cmd_oe_q  <= 1'b0;
                            crc_q     <= '0;
                            bit_cnt_q <= '0;
                            state_q   <= (rtype_q == 2'b00) ? S_DONE : S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (clk_en_i) begin
                        if (!cmd_in_i) begin
                            rx_sh_q   <= '0;
                            bit_cnt_q <= 8'd1;
                            state_q   <= S_RX;
                        end
`ifdef SDIO_CMD_TIMEOUT_EN
                        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                            timeout_q <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            to_cnt_q  <= to_cnt_q + 1'b1;
                        end
`endif
                    end
                end
                S_RX: begin
                    if (clk_en_i) begin
                        rx_sh_q   <= rx_full_d[132:0];
                        bit_cnt_q <= rx_bit_n_d;
                        if (rx_in_crc_d) begin
                            crc_q <= crc7_step(crc_q, cmd_in_i);
                        end
                        if (rx_bit_n_d == rx_len_d) begin
                            resp_index_q <= rx_long_d ? rx_full_d[133:128] : rx_full_d[45:40];
                            resp_data_q  <= rx_long_d ? RESP_W'(rx_full_d[127:0])
                                                      : RESP_W'({96'd0, rx_full_d[39:8]});
                            crc_err_q    <= (rtype_q != 2'b10) && (rx_full_d[7:1] != crc_q);
                            end_err_q    <= ~cmd_in_i;
                            state_q      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_out_o    = cmd_out_q;
    assign cmd_oe_o     = cmd_oe_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign resp_index_o = resp_index_q;
    assign resp_data_o  = resp_data_q;
    assign crc_err_o    = crc_err_q;
    assign end_err_o    = end_err_q;
`ifdef SDIO_CMD_TIMEOUT_EN
    assign timeout_o    = timeout_q;
`else
    assign timeout_o    = 1'b0;
`endif

endmodule
